// File: rtl/lsu_mem_arb.sv
//------------------------------------------------------------------------------
// lsu_mem_arb : LSU-side read/write queues arbitrated onto one memory bus,
//               with in-order read return and read-after-write hazard stall.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RDQ_DEPTH = 4,
    parameter int WQ_DEPTH  = 4,
    parameter int MAX_OUT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rdq_almost_full,
    output logic              wq_almost_full,
    output logic              ovf_err,
    output logic              spur_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int RQ_AW = $clog2(RDQ_DEPTH);
    localparam int WQ_AW = $clog2(WQ_DEPTH);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_RD = 2'd1,
        LOCK_WR = 2'd2
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] rq_mem [RDQ_DEPTH];
    logic [ADDR_W-1:0] wq_amem [WQ_DEPTH];
    logic [DATA_W-1:0] wq_dmem [WQ_DEPTH];
    logic [RQ_AW:0]    rq_wp, rq_rp, rq_cnt;
    logic [WQ_AW:0]    wq_wp, wq_rp, wq_cnt;
    logic [OUT_W-1:0]  out_cnt;

    logic              rq_full, wq_full, rq_push, wq_push;
    logic              rd_elig, wr_elig, hazard;
    logic              sel_rd, sel_wr, rd_gnt, wr_gnt, rsp_ok;
    logic [ADDR_W-1:0] rq_head_addr, wq_head_addr;
    logic [DATA_W-1:0] wq_head_data;
    logic [WQ_AW-1:0]  slot_off;

    assign rq_cnt       = rq_wp - rq_rp;
    assign wq_cnt       = wq_wp - wq_rp;
    assign rq_full      = (rq_cnt == (RQ_AW+1)'(RDQ_DEPTH));
    assign wq_full      = (wq_cnt == (WQ_AW+1)'(WQ_DEPTH));
    assign rq_push      = rd_valid && !rq_full;
    assign wq_push      = wr_valid && !wq_full;
    assign rq_head_addr = rq_mem[rq_rp[RQ_AW-1:0]];
    assign wq_head_addr = wq_amem[wq_rp[WQ_AW-1:0]];
    assign wq_head_data = wq_dmem[wq_rp[WQ_AW-1:0]];

    assign rdq_almost_full = (rq_cnt >= (RQ_AW+1)'(RDQ_DEPTH - 1));
    assign wq_almost_full  = (wq_cnt >= (WQ_AW+1)'(WQ_DEPTH - 1));

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        hazard   = 1'b0;
        slot_off = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            slot_off = WQ_AW'(i) - wq_rp[WQ_AW-1:0];
            if (((WQ_AW+1)'(slot_off) < wq_cnt) && (wq_amem[i] == rq_head_addr))
                hazard = 1'b1;
        end
    end

    assign rd_elig = (rq_cnt != '0) && (out_cnt < OUT_W'(MAX_OUT)) && !hazard;
    assign wr_elig = (wq_cnt != '0);

    always_comb begin
        sel_rd = 1'b0;
        sel_wr = 1'b0;
        case (state)
            IDLE: begin
                if (wr_elig && (!rd_elig || wq_almost_full))
                    sel_wr = 1'b1;
                else if (rd_elig)
                    sel_rd = 1'b1;
            end
            LOCK_RD: sel_rd = 1'b1;
            LOCK_WR: sel_wr = 1'b1;
            default: begin
                sel_rd = 1'b0;
                sel_wr = 1'b0;
            end
        endcase
    end

    assign bus_req   = sel_rd || sel_wr;
    assign bus_we    = sel_wr;
    assign bus_addr  = sel_wr ? wq_head_addr : (sel_rd ? rq_head_addr : '0);
    assign bus_wdata = sel_wr ? wq_head_data : '0;
    assign rd_gnt    = sel_rd && bus_gnt;
    assign wr_gnt    = sel_wr && bus_gnt;
    assign rsp_ok    = bus_rvalid && (out_cnt != '0);

    // Storage arrays carry no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (rq_push)
            rq_mem[rq_wp[RQ_AW-1:0]] <= rd_addr;
        if (wq_push) begin
            wq_amem[wq_wp[WQ_AW-1:0]] <= wr_addr;
            wq_dmem[wq_wp[WQ_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rq_wp    <= '0;
            rq_rp    <= '0;
            wq_wp    <= '0;
            wq_rp    <= '0;
            out_cnt  <= '0;
            rd_resp  <= 1'b0;
            rd_data  <= '0;
            ovf_err  <= 1'b0;
            spur_err <= 1'b0;
        end else begin
            if (rq_push) rq_wp <= rq_wp + 1'b1;
            if (wq_push) wq_wp <= wq_wp + 1'b1;
            if (rd_gnt)  rq_rp <= rq_rp + 1'b1;
            if (wr_gnt)  wq_rp <= wq_rp + 1'b1;
            if ((rd_valid && rq_full) || (wr_valid && wq_full))
                ovf_err <= 1'b1;
            if (bus_rvalid && (out_cnt == '0))
                spur_err <= 1'b1;

            if (rd_gnt && !rsp_ok)
                out_cnt <= out_cnt + 1'b1;
            else if (!rd_gnt && rsp_ok)
                out_cnt <= out_cnt - 1'b1;

            rd_resp <= rsp_ok;
            if (rsp_ok)
                rd_data <= bus_rdata;

            case (state)
                IDLE: begin
                    if (bus_req && !bus_gnt)
                        state <= sel_wr ? LOCK_WR : LOCK_RD;
                end
                LOCK_RD, LOCK_WR: begin
                    if (bus_gnt)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_arb.sv
//------------------------------------------------------------------------------
// tb_lsu_mem_arb : directed + randomized bench against a queue-based model.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_valid = 1'b0, wr_valid = 1'b0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        rd_resp, rdq_almost_full, wq_almost_full, ovf_err, spur_err;
    logic        bus_req, bus_we;
    logic [31:0] rd_data, bus_addr, bus_wdata;

    lsu_mem_arb dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_resp(rd_resp), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rdq_almost_full(rdq_almost_full), .wq_almost_full(wq_almost_full),
        .ovf_err(ovf_err), .spur_err(spur_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain in-order queues plus a few scalars.
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    logic [31:0] m_rq[$];
    wr_t         m_wq[$];
    int          m_out, m_lock;
    logic        m_ovf, m_spur, m_resp;
    logic [31:0] m_rdata;

    function automatic void model_reset();
        m_rq.delete(); m_wq.delete();
        m_out = 0; m_lock = 0;
        m_ovf = 0; m_spur = 0; m_resp = 0; m_rdata = '0;
    endfunction

    // One clock: drive inputs, compare every output at negedge, advance model.
    task automatic cycle(input logic rv, input logic [31:0] ra,
                         input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                         input logic g, input logic rvl, input logic [31:0] rdt);
        int  kind;
        bit  haz, rd_el, wr_el, rq_full0, wq_full0, inc;
        logic [31:0] e_addr, e_wdata;
        rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        bus_gnt = g; bus_rvalid = rvl; bus_rdata = rdt;
        @(negedge clk);
        haz = 0;
        if (m_rq.size() > 0)
            foreach (m_wq[i]) if (m_wq[i].a == m_rq[0]) haz = 1;
        rd_el = (m_rq.size() > 0) && (m_out < 4) && !haz;
        wr_el = (m_wq.size() > 0);
        if (m_lock != 0)                                kind = m_lock;
        else if (wr_el && (!rd_el || m_wq.size() >= 3)) kind = 2;
        else if (rd_el)                                 kind = 1;
        else                                            kind = 0;
        e_addr  = (kind == 1) ? m_rq[0] : (kind == 2) ? m_wq[0].a : 32'h0;
        e_wdata = (kind == 2) ? m_wq[0].d : 32'h0;
        check_eq("bus_req",   bus_req,   (kind != 0));
        check_eq("bus_we",    bus_we,    (kind == 2));
        check_eq("bus_addr",  bus_addr,  e_addr);
        check_eq("bus_wdata", bus_wdata, e_wdata);
        check_eq("rdq_af",    rdq_almost_full, (m_rq.size() >= 3));
        check_eq("wq_af",     wq_almost_full,  (m_wq.size() >= 3));
        check_eq("ovf_err",   ovf_err,  m_ovf);
        check_eq("spur_err",  spur_err, m_spur);
        check_eq("rd_resp",   rd_resp,  m_resp);
        check_eq("rd_data",   rd_data,  m_rdata);

        rq_full0 = (m_rq.size() == 4);
        wq_full0 = (m_wq.size() == 4);
        inc = 0;
        if (kind != 0 && g) begin
            if (kind == 1) begin void'(m_rq.pop_front()); inc = 1; end
            else           void'(m_wq.pop_front());
            m_lock = 0;
        end else if (kind != 0) begin
            m_lock = kind;
        end
        if (rvl) begin
            if (m_out > 0) begin m_out--; m_resp = 1; m_rdata = rdt; end
            else           begin m_spur = 1; m_resp = 0; end
        end else begin
            m_resp = 0;
        end
        if (inc) m_out++;
        if (rv) begin if (rq_full0) m_ovf = 1; else m_rq.push_back(ra); end
        if (wv) begin if (wq_full0) m_ovf = 1; else m_wq.push_back('{a: wa, d: wd}); end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic g);
        cycle(0, 0, 0, 0, 0, g, 0, 0);
    endtask

    // Returns responses for everything in flight; bounded so it always ends.
    task automatic drain();
        for (int i = 0; i < 40; i++)
            cycle(0, 0, 0, 0, 0, 1, (m_out > 0), $urandom);
    endtask

    task automatic do_reset();
        rd_valid = 0; wr_valid = 0; bus_gnt = 0; bus_rvalid = 0;
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("rst_bus_req", bus_req, 1'b0);
        check_eq("rst_flags", {bus_we, rd_resp, rdq_almost_full, wq_almost_full, ovf_err, spur_err}, 6'b0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_rd_data", rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single read, immediate grant, data two cycles after grant.
        cycle(1, 32'h100, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
        check_eq("t1_rd_resp", rd_resp, 1'b1);
        check_eq("t1_rd_data", rd_data, 32'hDEADBEEF);
        idle(0);
        check_eq("t1_rd_hold", rd_data, 32'hDEADBEEF);

        // Write then read of same address: write locked, read waits.
        cycle(0, 0, 1, 32'h40, 32'h5, 0, 0, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0);
        check_eq("t2_locked_we", bus_we, 1'b1);
        idle(1);
        check_eq("t2_read_after", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 32'h40});
        drain();

        // Read-queue overflow with bus stalled.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 32'h200 + 4*i, 0, 0, 0, 0, 0, 0);
        check_eq("t3_ovf", ovf_err, 1'b1);
        check_eq("t3_rdq_af", rdq_almost_full, 1'b1);
        drain();

        // Outstanding limit.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 32'h300 + 4*i, 0, 0, 0, 1, 0, 0);
        idle(1);
        check_eq("t4_blocked", bus_req, 1'b0);
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h1234);
        check_eq("t4_released", {bus_req, bus_addr}, {1'b1, 32'h310});
        drain();

        // Write priority while the write queue is nearly full.
        do_reset();
        cycle(0, 0, 1, 32'h10, 32'hA, 0, 0, 0);
        cycle(0, 0, 1, 32'h14, 32'hB, 0, 0, 0);
        cycle(0, 0, 1, 32'h18, 32'hC, 0, 0, 0);
        cycle(1, 32'h500, 1, 32'h1C, 32'hD, 0, 0, 0);
        idle(1);
        idle(1);
        check_eq("t5_read_wins", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 32'h500});
        drain();

        // Spurious rvalid, then reset in the middle of a locked write.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 32'hBAD);
        check_eq("t6_spur", spur_err, 1'b1);
        check_eq("t6_no_resp", rd_resp, 1'b0);
        cycle(0, 0, 1, 32'h80, 32'h9, 0, 0, 0);
        idle(0);
        do_reset();

        // Randomized traffic over a small address set to provoke hazards.
        for (int n = 0; n < 2500; n++) begin
            cycle($urandom_range(0, 2) == 0, {27'h0, 3'($urandom_range(0, 7)), 2'b00},
                  $urandom_range(0, 3) == 0, {27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom,
                  $urandom_range(0, 1) == 1, (m_out > 0) && ($urandom_range(0, 2) == 0), $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_arb.md
# lsu_mem_arb

Memory-side arbiter directly downstream of the load/store unit. Absorbs the LSU's unthrottled read requests and committed store writes into two in-order queues, arbitrates them onto a single-ported valid/grant memory bus, and returns read data to the LSU in request order. Stalls any read that overlaps a pending write, so no load reads stale memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RDQ_DEPTH, 4, read queue entries (power of 2, ≥2)
- WQ_DEPTH, 4, write queue entries (power of 2, ≥2)
- MAX_OUT, 4, max granted reads awaiting bus_rvalid (≥1)

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_valid  in  1  LSU read request (no backpressure)
- rd_addr  in  ADDR_W  read address
- rd_resp  out  1  read data valid to LSU
- rd_data  out  DATA_W  read data
- wr_valid  in  1  committed store write (no backpressure)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rdq_almost_full  out  1  read queue count ≥ RDQ_DEPTH-1
- wq_almost_full  out  1  write queue count ≥ WQ_DEPTH-1
- ovf_err  out  1  sticky: a request was dropped on a full queue
- spur_err  out  1  sticky: bus_rvalid with zero outstanding reads
- bus_req  out  1  bus request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  write data (0 on reads)
- bus_gnt  in  1  bus accepts request this cycle
- bus_rvalid  in  1  read data return, in grant order
- bus_rdata  in  DATA_W  read data

## Operation
- Read queue (RQ) and write queue (WQ): circular FIFOs, registered pointers with wrap bit; push on the rising edge where rd_valid / wr_valid is high.
- Push into a queue full at the start of the cycle is dropped and sets ovf_err, even if a pop occurs the same cycle. rd_valid and wr_valid in the same cycle both push.
- Read eligible: RQ non-empty, outstanding < MAX_OUT, and RQ head address matches no valid WQ entry (full-word compare). Write eligible: WQ non-empty.
- FSM: IDLE, LOCK_RD, LOCK_WR.
  - IDLE: if both eligible, pick the write when WQ count ≥ WQ_DEPTH-1, else the read. Otherwise pick whichever is eligible. Drive bus_req the same cycle. If bus_gnt is high, pop and stay in IDLE; otherwise go to LOCK_RD/LOCK_WR.
  - LOCK_*: hold bus_req=1 and bus_we/addr/wdata stable from the locked head until bus_gnt. Then pop and return to IDLE. Arbitration is frozen while locked.
- Outstanding counter (0..MAX_OUT): +1 on read grant, -1 on bus_rvalid; both in one cycle leaves it unchanged.
- bus_rvalid at outstanding == 0: set spur_err, leave the counter at 0, suppress rd_resp.
- Write grants produce no response.
- rd_resp/rd_data are bus_rvalid/bus_rdata registered one cycle. rd_data holds its last value when rd_resp is 0.

## Timing
- Reset (asynchronous, rst low): queues empty, counter 0, FSM IDLE, all outputs 0 (bus_req, bus_we, bus_addr, bus_wdata, rd_resp, rd_data, both almost_full flags, ovf_err, spur_err).
- Reset mid-transaction discards all queued and outstanding requests. Late bus_rvalid after reset sets spur_err.
- Bus outputs are combinational from FSM state and queue heads.
- A request pushed at edge N can appear on bus_req in cycle N+1 at the earliest.
- Read with immediate grant at edge N+1 and bus_rvalid in cycle K gives rd_resp in cycle K+1.
- Almost-full flags and the count ≥ WQ_DEPTH-1 check are registered-count based and update the cycle after a push or pop.
- Sticky errors clear only on reset.

## Test plan
- Read at 0x100, bus_gnt=1, bus_rvalid+0xDEADBEEF two cycles after grant → bus_req/we=0/addr=0x100 cycle N+1; rd_resp=1, rd_data=0xDEADBEEF one cycle after rvalid.
- Write 0x40←0x5; read 0x40 the next cycle; bus_gnt=0 for 3 cycles → write locked and held stable for 3 cycles, read issued only after the write grant.
- 5 reads back-to-back with RQ_DEPTH=4, bus_gnt=0 → 5th dropped, ovf_err=1, rdq_almost_full=1 after 3 entries.
- MAX_OUT=4, 5 reads granted, no rvalid → 5th read not requested until one bus_rvalid arrives.
- 3 writes queued plus pending read to a non-matching address → write wins while WQ count ≥3, read wins once count falls to 2.
- bus_rvalid with nothing outstanding → spur_err=1, rd_resp stays 0; async rst low mid-lock → bus_req drops immediately, all flags 0.
